sample_frame_scheduler: RTL
===========================

SAMPLE_FRAME_SCHEDULER -- requirements
Module: sample_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 6, log2 of samples per frame; FRAME_LEN = 2^FRAME_BITS.
REQ-002 SHALL have port inputClock  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port sampleTick  in  1  one-cycle pulse per audio sample period, for example from the 32 kHz divider.
REQ-005 SHALL have port sampleIn  in  8  unsigned microphone sample, valid when sampleTick=1.
REQ-006 SHALL have port enable  in  1  capture enable.
REQ-007 SHALL have port fftReady  in  1  FFT engine idle and able to accept a frame.
REQ-008 SHALL have port fftDone  in  1  one-cycle pulse marking FFT finished with the current frame.
REQ-009 SHALL have port fftReadAddr  in  FRAME_BITS  sample index the FFT reads.
REQ-010 SHALL have port fftReadData  out  8  sample at fftReadAddr in the dispatched bank.
REQ-011 SHALL have port fftStart  out  1  one-cycle pulse launching the FFT.
REQ-012 SHALL have port bankSelected  out  1  bank currently owned by the FFT.
REQ-013 SHALL have port busy  out  1  high while a dispatched frame is outstanding.
REQ-014 SHALL have port frameCount  out  16  completed frames; wraps on overflow.
REQ-015 SHALL have port overrunCount  out  8  dropped samples; saturates at 255.

Function
REQ-016 SHALL hold a 2 x FRAME_LEN x 8 ping-pong buffer (banks 0/1) with a full flag per bank; write bank wb, read bank rb, write index wi.
REQ-017 SHALL treat each cycle with sampleTick=1, enable=1, full[wb]=0 as a capture: mem[wb][wi] <= sampleIn, wi <= wi+1.
REQ-018 SHALL on capture at wi = FRAME_LEN-1: set full[wb], toggle wb, set wi <= 0, all in the same edge.
REQ-019 SHALL on sampleTick=1, enable=1, full[wb]=1: drop the sample, leave memory and wi unchanged, increment overrunCount (saturating).
REQ-020 SHALL ignore sampleTick while enable=0, with no overrun; the cycle after enable falls, wi <= 0 (partial frame discarded). Full banks are kept.
REQ-021 SHALL implement the dispatcher FSM with states D_IDLE and D_RUN.
REQ-022 SHALL in D_IDLE with full[rb]=1 and fftReady=1: assert fftStart for exactly one cycle and enter D_RUN.
REQ-023 SHALL in D_RUN with fftDone=1: clear full[rb], toggle rb, increment frameCount, return to D_IDLE. Other inputs hold state.
REQ-024 SHALL ignore fftDone in D_IDLE.
REQ-025 SHALL register fftStart; for a frame completed by the tick at cycle T, with dispatcher idle and fftReady=1, fftStart is high in cycle T+2.
REQ-026 SHALL drive bankSelected = rb and busy = (state == D_RUN).
REQ-027 SHALL return fftReadData = mem[rb][fftReadAddr] registered, valid one cycle after the address. Contents are stable while busy.
REQ-028 SHALL evaluate a full flag cleared by fftDone from the next cycle on; a tick in the same cycle sees the old flag and is dropped per REQ-019.
REQ-029 SHALL never write to bank rb while busy=1.

Reset
REQ-030 SHALL on reset=1 at a clock edge set wb=0, rb=0, wi=0, full[1:0]=0, state=D_IDLE, fftStart=0, fftReadData=0, frameCount=0, overrunCount=0, overriding all other inputs. Memory contents are don't-care.
REQ-031 SHALL when reset occurs in D_RUN abandon the frame; a later fftDone is ignored per REQ-024.

Verification (FRAME_BITS=2, FRAME_LEN=4)
REQ-032 SHALL cover: reset, fftReady=1, ticks with 10,20,30,40 -> fftStart single pulse 2 cycles after 4th tick, bankSelected=0, busy=1; addr 0..3 reads 10,20,30,40 one cycle later.
REQ-033 SHALL cover: after REQ-032, fftDone pulse, then ticks 50,60,70,80 -> frameCount=1; fftStart with bankSelected=1; reads 50..80.
REQ-034 SHALL cover: fftReady=0, 11 ticks -> both banks full after 8, overrunCount=3, bank 0 still reads first 4 samples, no fftStart.
REQ-035 SHALL cover: both banks full, busy, fftDone coincident with tick -> that sample dropped (overrunCount+1); next tick writes bank 0 index 0.
REQ-036 SHALL cover: reset during D_RUN, then fftDone -> all outputs at reset values, frameCount stays 0, no fftStart.
REQ-037 SHALL cover: 2 ticks, enable low with 3 ticks, enable high with 4 ticks 1,2,3,4 -> overrunCount=0; frame in bank 0 reads 1,2,3,4.

Source files
------------

// File: rtl/sample_frame_scheduler.sv
// Sample frame scheduler: captures microphone samples into a ping-pong pair of
// frame banks and hands each completed bank to the FFT engine, one at a time.
module sample_frame_scheduler #(
    parameter int FRAME_BITS = 6
) (
    input  logic                  inputClock,
    input  logic                  reset,
    input  logic                  sampleTick,
    input  logic [7:0]            sampleIn,
    input  logic                  enable,
    input  logic                  fftReady,
    input  logic                  fftDone,
    input  logic [FRAME_BITS-1:0] fftReadAddr,
    output logic [7:0]            fftReadData,
    output logic                  fftStart,
    output logic                  bankSelected,
    output logic                  busy,
    output logic [15:0]           frameCount,
    output logic [7:0]            overrunCount
);

    localparam int FRAME_LEN = 2 ** FRAME_BITS;
    localparam logic [FRAME_BITS-1:0] LAST_IDX = FRAME_BITS'(FRAME_LEN - 1);

    typedef enum logic {
        D_IDLE = 1'b0,
        D_RUN  = 1'b1
    } disp_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    disp_state_t           state_q, state_d;
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic [FRAME_BITS-1:0] wi_q, wi_d;
    logic [1:0]            full_q, full_d;
    logic                  start_q, start_d;
    logic [15:0]           frames_q, frames_d;
    logic [7:0]            overrun_q, overrun_d;
    logic [7:0]            rdata_q;
    logic [7:0]            mem_q [2*FRAME_LEN];

    logic                  capture;
    logic                  drop;
    logic                  frame_end;

    // Capture/drop decisions use the registered full flags, so a flag cleared
    // by fftDone only admits samples from the following cycle on.
    always_comb begin
        capture   = sampleTick && enable && !full_q[wb_q];
        drop      = sampleTick && enable && full_q[wb_q];
        frame_end = capture && (wi_q == LAST_IDX);

        state_d   = state_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wi_d      = wi_q;
        full_d    = full_q;
        start_d   = 1'b0;
        frames_d  = frames_q;
        overrun_d = overrun_q;

        if (!enable) begin
            wi_d = '0;
        end else if (capture) begin
            wi_d = frame_end ? '0 : wi_q + FRAME_BITS'(1);
        end

        if (frame_end) begin
            full_d[wb_q] = 1'b1;
            wb_d         = !wb_q;
        end

        if (drop) begin
            overrun_d = sat_inc8(overrun_q);
        end

        case (state_q)
            D_IDLE: begin
                if (full_q[rb_q] && fftReady) begin
                    start_d = 1'b1;
                    state_d = D_RUN;
                end
            end
            D_RUN: begin
                if (fftDone) begin
                    full_d[rb_q] = 1'b0;
                    rb_d         = !rb_q;
                    frames_d     = frames_q + 16'd1;
                    state_d      = D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    // Control state: bank pointers, write index, full flags, dispatcher, counters.
    always_ff @(posedge inputClock) begin
        if (reset) begin
            state_q   <= D_IDLE;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wi_q      <= '0;
            full_q    <= 2'b00;
            start_q   <= 1'b0;
            frames_q  <= 16'd0;
            overrun_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            wi_q      <= wi_d;
            full_q    <= full_d;
            start_q   <= start_d;
            frames_q  <= frames_d;
            overrun_q <= overrun_d;
        end
    end

    // Sample storage; only the bank being filled is ever written.
    always_ff @(posedge inputClock) begin
        if (!reset && capture) begin
            mem_q[{wb_q, wi_q}] <= sampleIn;
        end
    end

    // Registered FFT read port into the bank the dispatcher owns.
    always_ff @(posedge inputClock) begin
        if (reset) begin
            rdata_q <= 8'd0;
        end else begin
            rdata_q <= mem_q[{rb_q, fftReadAddr}];
        end
    end

    assign fftReadData  = rdata_q;
    assign fftStart     = start_q;
    assign bankSelected = rb_q;
    assign busy         = (state_q == D_RUN);
    assign frameCount   = frames_q;
    assign overrunCount = overrun_q;

endmodule
